// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin drain of private ALU/LSB result FIFOs onto one registered CDB; CDB_STATS_EN adds grant counters and overflow flags.
// Latency: one cycle from FIFO write to broadcast at minimum; full flags backpressure the sources and inputs arriving while full are dropped.

module cdb_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         clr,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_rdy)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_vld, pop_rdy})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_vld)
            mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
endmodule

module cdb_arbiter #(
    parameter int ROB_W      = 3,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              alu_valid_in,
    input  logic [ROB_W-1:0]  alu_robid_in,
    input  logic [DATA_W-1:0] alu_val_in,
    output logic              alu_full_out,
    input  logic              lsb_valid_in,
    input  logic [ROB_W-1:0]  lsb_robid_in,
    input  logic [DATA_W-1:0] lsb_val_in,
    output logic              lsb_full_out,
    output logic              cdb_valid_out,
    output logic [ROB_W-1:0]  cdb_robid_out,
    output logic [DATA_W-1:0] cdb_val_out,
    output logic              cdb_src_out
`ifdef CDB_STATS_EN
    ,
    output logic [15:0]       alu_grant_cnt_out,
    output logic [15:0]       lsb_grant_cnt_out,
    output logic [1:0]        ovf_out
`endif
);
    localparam int EW = ROB_W + DATA_W;

    logic          cycle_en;
    logic          alu_push_vld, lsb_push_vld;
    logic          alu_empty, lsb_empty;
    logic [EW-1:0] alu_head_dat, lsb_head_dat;
    logic          gnt_alu, gnt_lsb;
    logic          rr_lsb;

    assign cycle_en     = rdy_in & ~clear_in;
    assign alu_push_vld = cycle_en & alu_valid_in & ~alu_full_out;
    assign lsb_push_vld = cycle_en & lsb_valid_in & ~lsb_full_out;

    cdb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clr      (clear_in),
        .push_vld (alu_push_vld),
        .push_dat ({alu_robid_in, alu_val_in}),
        .pop_rdy  (gnt_alu),
        .head_dat (alu_head_dat),
        .full     (alu_full_out),
        .empty    (alu_empty)
    );

    cdb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clr      (clear_in),
        .push_vld (lsb_push_vld),
        .push_dat ({lsb_robid_in, lsb_val_in}),
        .pop_rdy  (gnt_lsb),
        .head_dat (lsb_head_dat),
        .full     (lsb_full_out),
        .empty    (lsb_empty)
    );

    // Only entries present at the start of the cycle compete, so a fresh write never bypasses.
    assign gnt_alu = cycle_en & ~alu_empty & (~rr_lsb | lsb_empty);
    assign gnt_lsb = cycle_en & ~lsb_empty & (rr_lsb | alu_empty);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid_out <= 1'b0;
            cdb_robid_out <= '0;
            cdb_val_out   <= '0;
            cdb_src_out   <= 1'b0;
            rr_lsb        <= 1'b0;
        end else if (clear_in) begin
            cdb_valid_out <= 1'b0;
            rr_lsb        <= 1'b0;
        end else if (rdy_in) begin
            cdb_valid_out <= gnt_alu | gnt_lsb;
            if (gnt_alu) begin
                {cdb_robid_out, cdb_val_out} <= alu_head_dat;
                cdb_src_out <= 1'b0;
                rr_lsb      <= 1'b1;
            end else if (gnt_lsb) begin
                {cdb_robid_out, cdb_val_out} <= lsb_head_dat;
                cdb_src_out <= 1'b1;
                rr_lsb      <= 1'b0;
            end
        end
    end

`ifdef CDB_STATS_EN
    // Survives flushes on purpose; only a hard reset clears the statistics.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            alu_grant_cnt_out <= '0;
            lsb_grant_cnt_out <= '0;
            ovf_out           <= '0;
        end else begin
            if (gnt_alu)
                alu_grant_cnt_out <= alu_grant_cnt_out + 16'd1;
            if (gnt_lsb)
                lsb_grant_cnt_out <= lsb_grant_cnt_out + 16'd1;
            if (cycle_en & alu_valid_in & alu_full_out)
                ovf_out[0] <= 1'b1;
            if (cycle_en & lsb_valid_in & lsb_full_out)
                ovf_out[1] <= 1'b1;
        end
    end
`endif
endmodule
